// File: rtl/pht_pkg.sv
// Shared encodings for the pattern history table: 2-bit counter values and
// the init/run state type.
package pht_pkg;

  localparam logic [1:0] CTR_SNT  = 2'b00;
  localparam logic [1:0] CTR_WNT  = 2'b01;
  localparam logic [1:0] CTR_WT   = 2'b10;
  localparam logic [1:0] CTR_ST   = 2'b11;
  localparam logic [1:0] CTR_INIT = CTR_WNT;

  typedef enum logic {
    PHT_INIT,
    PHT_RUN
  } pht_state_e;

endpackage

// File: rtl/pht_sat_ctr.sv
// Combinational 2-bit saturating counter step; shared with the BTB hysteresis bits.
module pht_sat_ctr
  import pht_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic t);
    if (t) begin
      return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    end
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

  always_comb begin
    ctr_nxt = sat_step(ctr, taken);
  end

endmodule

// File: rtl/pht_table.sv
// Pattern history table: post-reset sweep to weakly-not-taken, 1-cycle lookups,
// 2-stage counter updates. Define PHT_BYPASS_EN for write-first lookup/update collisions.
module pht_table
  import pht_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int k_width    = 12
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               pred_valid,
  input  logic [k_width-1:0] pred_idx,
  output logic               pred_resp_valid,
  output logic               pred_taken,
  input  logic               upd_valid,
  input  logic [k_width-1:0] upd_idx,
  input  logic               upd_taken,
  output logic               init_done
);

  localparam int DEPTH = 2 ** k_width;

  // The index is a fold of the PC, so it can never be wider than the PC.
  if (k_width > ADDR_WIDTH) begin : g_cfg_check
    $error("pht_table: k_width exceeds ADDR_WIDTH");
  end

  logic [1:0]         ctr_mem [DEPTH];
  pht_state_e         state;
  logic [k_width-1:0] init_ptr;

  logic               upd_vld_p1;
  logic [k_width-1:0] upd_idx_p1;
  logic               upd_taken_p1;
  logic [1:0]         upd_ctr_p1;
  logic [1:0]         upd_nxt_p1;
  logic               pred_msb_p0;

  // ---- stage p0: lookup read, stage p1: update read-modify ----
  assign upd_ctr_p1 = ctr_mem[upd_idx_p1];

  pht_sat_ctr u_sat_ctr (
    .ctr     (upd_ctr_p1),
    .taken   (upd_taken_p1),
    .ctr_nxt (upd_nxt_p1)
  );

  always_comb begin
    pred_msb_p0 = ctr_mem[pred_idx][1];
`ifdef PHT_BYPASS_EN
    if (upd_vld_p1 && (upd_idx_p1 == pred_idx)) begin
      pred_msb_p0 = upd_nxt_p1[1];
    end
`endif
  end

  // ---- control registers ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= PHT_INIT;
      init_ptr        <= '0;
      init_done       <= 1'b0;
      upd_vld_p1      <= 1'b0;
      pred_resp_valid <= 1'b0;
      pred_taken      <= 1'b0;
    end else begin
      case (state)
        PHT_INIT: begin
          init_ptr        <= init_ptr + k_width'(1);
          upd_vld_p1      <= 1'b0;
          pred_resp_valid <= 1'b0;
          pred_taken      <= 1'b0;
          if (&init_ptr) begin
            state     <= PHT_RUN;
            init_done <= 1'b1;
          end
        end
        PHT_RUN: begin
          upd_vld_p1      <= upd_valid;
          pred_resp_valid <= pred_valid;
          pred_taken      <= pred_valid & pred_msb_p0;
        end
        default: begin
          state <= PHT_INIT;
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: update payload (qualified by upd_vld_p1) ----
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      upd_idx_p1   <= upd_idx;
      upd_taken_p1 <= upd_taken;
    end
  end

  // Single write port: the sweep owns it in INIT, stage p1 owns it in RUN.
  always_ff @(posedge clk) begin
    if (state == PHT_INIT) begin
      ctr_mem[init_ptr] <= CTR_INIT;
    end else if (upd_vld_p1) begin
      ctr_mem[upd_idx_p1] <= upd_nxt_p1;
    end
  end

endmodule

// File: tb/tb_pht_table.sv
// Scoreboard bench for pht_table (k_width=12); honours PHT_BYPASS_EN when defined.
module tb_pht_table;

  localparam int K     = 12;
  localparam int DEPTH = 4096;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         pred_valid = 1'b0;
  logic [K-1:0] pred_idx = '0;
  logic         pred_resp_valid;
  logic         pred_taken;
  logic         upd_valid = 1'b0;
  logic [K-1:0] upd_idx = '0;
  logic         upd_taken = 1'b0;
  logic         init_done;

  always #5 clk = ~clk;

  pht_table #(.ADDR_WIDTH(30), .k_width(K)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .pred_valid      (pred_valid),
    .pred_idx        (pred_idx),
    .pred_resp_valid (pred_resp_valid),
    .pred_taken      (pred_taken),
    .upd_valid       (upd_valid),
    .upd_idx         (upd_idx),
    .upd_taken       (upd_taken),
    .init_done       (init_done)
  );

  typedef struct {
    logic [K-1:0] idx;
    logic         tk;
  } exp_t;

  int          errs = 0;
  int          chks = 0;
  exp_t        exp_q[$];
  logic [1:0]  model [DEPTH];
  bit          pend_v = 1'b0;
  logic [K-1:0] pend_idx = '0;
  logic [1:0]  pend_old = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  always @(posedge clk) begin
    #1;
    if (pred_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq($sformatf("pred_taken@%0h", e.idx), {31'd0, pred_taken}, {31'd0, e.tk});
      end
    end
  end

  // One RUN cycle of stimulus, called at a falling edge; keeps the model in step.
  task automatic drive(input bit pv, input logic [K-1:0] pidx,
                       input bit uv, input logic [K-1:0] uidx, input bit ut);
    exp_t e;
    logic [1:0] old;
    pred_valid = pv;
    pred_idx   = pidx;
    upd_valid  = uv;
    upd_idx    = uidx;
    upd_taken  = ut;
    if (pv) begin
      e.idx = pidx;
      e.tk  = model[pidx][1];
`ifndef PHT_BYPASS_EN
      if (pend_v && pend_idx == pidx) e.tk = pend_old[1];
`endif
      exp_q.push_back(e);
    end
    old = model[uidx];
    if (uv) model[uidx] = sat(old, ut);
    pend_v   = uv;
    pend_idx = uidx;
    pend_old = old;
    @(negedge clk);
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic lookup(input logic [K-1:0] idx);
    drive(1'b1, idx, 1'b0, '0, 1'b0);
  endtask

  task automatic update(input logic [K-1:0] idx, input bit t);
    drive(1'b0, '0, 1'b1, idx, t);
  endtask

  // Called at the falling edge right after rstn release; returns the cycle init_done rose.
  task automatic wait_init(input bit junk, output int k, output int resp_seen);
    k = 0;
    resp_seen = 0;
    if (junk) begin
      pred_valid = 1'b1; pred_idx = 12'h123;
      upd_valid  = 1'b1; upd_idx  = 12'h123; upd_taken = 1'b1;
    end
    for (int i = 1; i <= 5000; i++) begin
      @(posedge clk);
      #1;
      if (pred_resp_valid === 1'b1) resp_seen++;
      if (i == 4000) begin
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
      end
      if (init_done === 1'b1) begin
        k = i;
        break;
      end
    end
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    @(negedge clk);
    pend_v = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 2'b01;
  endtask

  logic [K-1:0] pool [4];

  initial begin
    int k;
    int rs;
    pool[0] = 12'h010; pool[1] = 12'h011; pool[2] = 12'h3C1; pool[3] = 12'h800;

    repeat (3) @(negedge clk);
    check_eq("rst_init_done", {31'd0, init_done}, 0);
    check_eq("rst_resp_valid", {31'd0, pred_resp_valid}, 0);
    check_eq("rst_pred_taken", {31'd0, pred_taken}, 0);
    rstn = 1'b1;

    // First sweep with lookups/updates at 0x123 that must be ignored
    wait_init(1'b1, k, rs);
    check_eq("init_len", k, 4096);
    check_eq("init_resp_valid", rs, 0);
    lookup(12'h000);
    lookup(12'hFFF);
    lookup(12'h123);
    idle(2);

    // Saturation walk at 0x0A5 (back-to-back updates included)
    update(12'h0A5, 1'b1); update(12'h0A5, 1'b1); update(12'h0A5, 1'b1);
    idle(1); lookup(12'h0A5);
    update(12'h0A5, 1'b0); idle(1); lookup(12'h0A5);
    update(12'h0A5, 1'b0); update(12'h0A5, 1'b0); idle(1); lookup(12'h0A5);
    update(12'h0A5, 1'b0); idle(1); lookup(12'h0A5);
    update(12'h0A5, 1'b1); idle(1); lookup(12'h0A5);
    update(12'h0A5, 1'b1); idle(1); lookup(12'h0A5);
    idle(2);

    // Collision at 0x3C0: lookup one cycle after the update
    update(12'h3C0, 1'b1);
    lookup(12'h3C0);
    lookup(12'h3C0);
    idle(2);
    check_eq("idle_resp_valid", {31'd0, pred_resp_valid}, 0);
    check_eq("idle_pred_taken", {31'd0, pred_taken}, 0);

    // Mixed random traffic over a small index pool
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
            1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
            1'($urandom_range(0, 1)));
    end
    idle(2);

    // Reset during RUN after training 0x7FF to strongly taken
    update(12'h7FF, 1'b1); update(12'h7FF, 1'b1); update(12'h7FF, 1'b1);
    idle(1); lookup(12'h7FF);
    idle(2);
    rstn = 1'b0;
    #1;
    check_eq("run_rst_init_done", {31'd0, init_done}, 0);
    check_eq("run_rst_resp_valid", {31'd0, pred_resp_valid}, 0);
    @(negedge clk);
    rstn = 1'b1;
    wait_init(1'b0, k, rs);
    check_eq("reinit_len", k, 4096);
    lookup(12'h7FF);
    idle(2);

    // Reset at sweep cycle 1000
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check_eq("mid_init_done", {31'd0, init_done}, 0);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_init_done", {31'd0, init_done}, 0);
    @(negedge clk);
    rstn = 1'b1;
    wait_init(1'b0, k, rs);
    check_eq("mid_reinit_len", k, 4096);
    lookup(12'h0A5);
    lookup(12'h3C0);
    idle(3);

    check_eq("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/pht_table.md
# pht_table

Pattern history table for the branch predictor front end. It consumes the 12-bit XOR-folded PC index on two paths: a fetch-side prediction read and a commit-side update of a 2-bit saturating counter. After reset it runs a sweep FSM that writes every entry to weakly-not-taken, then serves predictions with one-cycle read latency. It sits between the fetch-stage index hash and the next-PC select logic.

## Interface
- `ADDR_WIDTH`, 30: PC width (word address); carried for consistency with the index producer, unused internally.
- `k_width`, 12: index width; table depth is 2^k_width entries of 2 bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `pred_valid`  in  1  prediction lookup request.
- `pred_idx`  in  k_width  hashed fetch-PC index.
- `pred_resp_valid`  out  1  lookup result valid.
- `pred_taken`  out  1  predicted direction, counter MSB.
- `upd_valid`  in  1  commit-side update request.
- `upd_idx`  in  k_width  hashed branch-PC index.
- `upd_taken`  in  1  resolved branch direction.
- `init_done`  out  1  table initialised; lookups and updates accepted.

## Operation
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Taken increments the counter, saturating at 11. Not-taken decrements it, saturating at 00.
- FSM states:
  - INIT: entry `init_ptr` is written with 01 each cycle. `init_ptr` increments with k_width-bit wrap. On the write to the all-ones entry, the next state is RUN.
  - RUN: the terminal state. Only `rstn` leaves it.
- In INIT:
  - `pred_valid` and `upd_valid` are ignored; nothing is queued.
  - `pred_resp_valid` and `pred_taken` are held at 0.
- Lookup in RUN:
  - `pred_valid` in cycle N latches `ctr[pred_idx]` into the output register.
  - `pred_resp_valid` is 1 in N+1. `pred_taken` is the latched counter's MSB.
  - With no request, `pred_resp_valid` is 0 and `pred_taken` is 0.
- Update in RUN (two stages):
  - `upd_valid`/`upd_idx`/`upd_taken` in cycle N are registered into stage U1.
  - In N+1, U1 reads `ctr[upd_idx]`, computes the saturated next value, and writes it at the end of N+1.
- Back-to-back updates to the same index (N and N+1):
  - The second update reads the array in N+2, after the first write has landed.
  - No hazard; both increments apply. Example: 01 → 10 → 11.
- Simultaneous lookup and U1 write to the same index in the same cycle: see Configuration.
- Simultaneous lookup and a newly arriving update (still entering U1) never interact.
- Reset asserted at any time:
  - FSM returns to INIT, `init_ptr` = 0, U1 valid is cleared.
  - The whole table is re-swept.
- Reset values: `pred_resp_valid`=0, `pred_taken`=0, `init_done`=0, U1 valid=0.
- Array contents are not reset; the sweep defines them.

## Timing
- INIT lasts exactly 2^k_width cycles after `rstn` deassertion (4096 at default).
- `init_done` is registered:
  - It goes to 1 in the first RUN cycle.
  - A `pred_valid` in that cycle gets a response the next cycle.
- Lookup latency: 1 cycle. Throughput: 1 lookup per cycle.
- Update: visible to a lookup issued 2 cycles after `upd_valid` (bypass off) or 1 cycle after (bypass on). Throughput: 1 update per cycle.
- No backpressure on either path.

## Configuration
- Macro: `PHT_BYPASS_EN`.
- Defined: when a lookup reads the same index that U1 writes in the same cycle, the output register takes U1's new counter value (write-first).
- Undefined: the output register takes the old array value (read-first). The update still lands.

## Structure
- `pht_pkg` holds:
  - counter localparams `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`;
  - init value `CTR_INIT = CTR_WNT`;
  - FSM state typedef `{PHT_INIT, PHT_RUN}`.
- Sub-module `pht_sat_ctr`: combinational 2-bit saturating next-state function with inputs `ctr`, `taken` and output `ctr_nxt`. It is reused by the BTB hysteresis bits.

## Test plan
- Reset then idle (k_width=12): `init_done`=0 for 4096 cycles and 1 on cycle 4097. A lookup at 0x000 and at 0xFFF each returns `pred_taken`=0.
- Lookups driven during INIT at idx 0x123: `pred_resp_valid` stays 0. Updates during INIT at 0x123, taken=1: lookup after INIT returns 0 (the update was dropped).
- Saturation at idx 0x0A5:
  - 3 taken updates, then lookup → `pred_taken`=1, counter 11.
  - 1 not-taken update → 1 (counter 10).
  - 2 more not-taken → 0 (counter 00).
  - 1 more not-taken → counter stays 00.
- Collision at idx 0x3C0 (counter 01): update taken in N, lookup in N+1 at the same index.
  - With `PHT_BYPASS_EN`: `pred_taken`=1 in N+2.
  - Without: `pred_taken`=0 in N+2, and a repeat lookup in N+2 returns 1 in N+3.
- Reset mid-RUN after training idx 0x7FF to 11: `rstn` low for 1 cycle. `init_done` falls and a full 4096-cycle sweep follows; the lookup at 0x7FF afterwards returns 0.
- Reset mid-INIT at sweep cycle 1000: INIT restarts from 0 and `init_done` rises 4096 cycles after release.
